// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter sharing one UART transmitter
//            among NUM_REQ AXI-Stream byte sources, with an optional source
//            header byte and a per-grant burst limit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int           NUM_REQ    = 4,
    parameter int           DATA_WIDTH = 8,
    parameter bit           HEADER_EN  = 1'b1,
    parameter logic [7:0]   HDR_BASE   = 8'hA0,
    parameter int           MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    input  logic [NUM_REQ-1:0]            req_tlast,
    output logic [NUM_REQ-1:0]            req_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          burst_truncated
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hdr  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_id_w-1:0]     r_last_id;
    logic [c_cnt_w-1:0]    r_beat_cnt;
    logic [c_id_w-1:0]     w_scan_id [NUM_REQ];
    logic [c_id_w-1:0]     w_pick_id;
    logic                  w_pick_found;
    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_g_data;
    logic [DATA_WIDTH-1:0] w_hdr;
    logic                  w_g_valid;
    logic                  w_g_last;
    logic                  w_hs;
    logic                  w_limit_beat;
    logic                  w_release;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi] = req_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_g_data  = w_req_data[grant_id];
    assign w_g_valid = req_tvalid[grant_id];
    assign w_g_last  = req_tlast[grant_id];
    assign w_hdr     = DATA_WIDTH'(HDR_BASE + 8'(grant_id));

    // Candidate order: last_id+1, last_id+2, ... wrapping modulo NUM_REQ.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_id[k] = c_id_w'((int'(r_last_id) + k + 1) % NUM_REQ);
        end
    end

    always_comb begin
        w_pick_id    = '0;
        w_pick_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_pick_found && req_tvalid[w_scan_id[k]]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_scan_id[k];
            end
        end
    end

    assign w_hs         = (r_state == c_st_data) && w_g_valid && m_axis_tready;
    // The counter holds beats already sent, so the limit beat is MAX_BURST-1.
    assign w_limit_beat = (MAX_BURST != 0) && (r_beat_cnt == c_cnt_w'(MAX_BURST - 1));
    assign w_release    = w_hs && (w_g_last || w_limit_beat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_pick_found) begin
                    w_state_next = HEADER_EN ? c_st_hdr : c_st_data;
                end
            end
            c_st_hdr: begin
                if (m_axis_tready) begin
                    w_state_next = c_st_data;
                end
            end
            c_st_data: begin
                if (w_release) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        req_tready    = '0;
        grant_valid   = 1'b0;
        case (r_state)
            c_st_hdr: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w_hdr;
                grant_valid   = 1'b1;
            end
            c_st_data: begin
                m_axis_tvalid        = w_g_valid;
                m_axis_tdata         = w_g_valid ? w_g_data : '0;
                req_tready[grant_id] = m_axis_tready;
                grant_valid          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id        <= '0;
            r_last_id       <= c_id_w'(NUM_REQ - 1);
            r_beat_cnt      <= '0;
            burst_truncated <= 1'b0;
        end else begin
            burst_truncated <= w_hs && w_limit_beat && !w_g_last;
            if ((r_state == c_st_idle) && w_pick_found) begin
                grant_id   <= w_pick_id;
                r_beat_cnt <= '0;
            end else if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end
            if (w_release) begin
                r_last_id <= grant_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench: queue-driven sources, transaction-level
//            arbitration model, directed literal sequences plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    typedef logic [7:0] u8_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*DW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tlast;
    logic [N-1:0]    req_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            burst_truncated;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .HEADER_EN  (1'b1),
        .HDR_BASE   (8'hA0),
        .MAX_BURST  (MB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_tdata       (req_tdata),
        .req_tvalid      (req_tvalid),
        .req_tlast       (req_tlast),
        .req_tready      (req_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .burst_truncated (burst_truncated)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Source queues: {tlast, byte}
    logic [8:0] q [N][$];
    bit         offer [N];
    bit         hs [N];
    int         valid_pct  = 100;
    bit         ready_rand = 1'b0;
    int         bp_cnt     = 0;
    bit         in_reset   = 1'b1;

    // Model: phase 0 = no owner, 1 = header owed, 2 = streaming owner's bytes
    int  m_phase = 0;
    int  m_gid   = 0;
    int  m_last  = N - 1;
    int  m_beats = 0;
    bit  m_trunc = 1'b0;
    u8_t log_q [$];
    int  trunc_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input u8_t first);
        for (int b = 0; b < len; b++) begin
            q[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, u8_t'(first + u8_t'(b))});
        end
    endtask

    function automatic bit busy();
        bit b = (m_phase != 0);
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0 || offer[i]) b = 1'b1;
        end
        return b;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (busy() && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk({name, "_timeout"}, 32'(busy()), 32'd0);
    endtask

    task automatic chk_log(input string name, input u8_t e[$]);
        chk({name, "_len"}, log_q.size(), e.size());
        for (int k = 0; k < e.size() && k < log_q.size(); k++) begin
            chk({name, "_byte"}, log_q[k], e[k]);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        in_reset = 1'b1;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tready", req_tready, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_trunc", burst_truncated, 0);
        @(posedge clk); #2;
        rst      = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic step_model();
        logic [7:0]   e_data  = '0;
        logic         e_valid = 1'b0;
        logic [N-1:0] e_ready = '0;
        logic         e_gv    = 1'b0;
        int           g       = m_gid;
        bit           found   = 1'b0;
        if (m_phase == 1) begin
            e_valid = 1'b1;
            e_data  = 8'hA0 + 8'(g);
            e_gv    = 1'b1;
        end else if (m_phase == 2) begin
            e_gv       = 1'b1;
            e_valid    = req_tvalid[g];
            if (e_valid) e_data = q[g][0][7:0];
            e_ready[g] = m_axis_tready;
        end
        chk("tvalid", m_axis_tvalid, e_valid);
        chk("tdata", m_axis_tdata, e_data);
        chk("req_tready", req_tready, e_ready);
        chk("grant_valid", grant_valid, e_gv);
        chk("grant_id", grant_id, g);
        chk("burst_truncated", burst_truncated, m_trunc);

        for (int i = 0; i < N; i++) hs[i] = req_tvalid[i] && req_tready[i];
        if (m_axis_tvalid && m_axis_tready) log_q.push_back(m_axis_tdata);
        if (burst_truncated) trunc_seen++;

        m_trunc = 1'b0;
        case (m_phase)
            0: begin
                for (int k = 1; k <= N; k++) begin
                    automatic int idx = (m_last + k) % N;
                    if (!found && req_tvalid[idx]) begin
                        found = 1'b1;
                        m_gid = idx;
                    end
                end
                if (found) begin
                    m_phase = 1;
                    m_beats = 0;
                end
            end
            1: if (m_axis_tready) m_phase = 2;
            default: begin
                if (req_tvalid[g] && m_axis_tready) begin
                    m_beats++;
                    if (q[g][0][8]) begin
                        m_last  = g;
                        m_phase = 0;
                    end else if (m_beats == MB) begin
                        m_last  = g;
                        m_phase = 0;
                        m_trunc = 1'b1;
                    end
                end
            end
        endcase
    endtask

    // Compare process: every negedge, outputs are settled and away from the edge
    initial begin
        forever begin
            @(negedge clk);
            if (in_reset) begin
                m_phase = 0; m_gid = 0; m_last = N - 1; m_beats = 0; m_trunc = 1'b0;
                for (int i = 0; i < N; i++) hs[i] = 1'b0;
            end else begin
                step_model();
            end
        end
    end

    // Source / sink driver: AXI sources keep valid asserted until accepted
    initial begin
        req_tdata     = '0;
        req_tvalid    = '0;
        req_tlast     = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    q[i].delete(0);
                    offer[i] = 1'b0;
                end
                if (!offer[i] && q[i].size() > 0 && int'($urandom_range(99)) < valid_pct)
                    offer[i] = 1'b1;
                req_tvalid[i]          = offer[i];
                req_tdata[i*DW +: DW]  = offer[i] ? q[i][0][7:0] : 8'h00;
                req_tlast[i]           = offer[i] ? q[i][0][8] : 1'b0;
            end
            m_axis_tready = (bp_cnt == 0) && (!ready_rand || $urandom_range(3) != 0);
            if (bp_cnt > 0) bp_cnt--;
        end
    end

    initial begin
        u8_t e [$];
        bit  did_reset = 1'b0;
        #1;
        chk("init_tvalid", m_axis_tvalid, 0);
        chk("init_tdata", m_axis_tdata, 0);
        chk("init_tready", req_tready, 0);
        chk("init_grant_valid", grant_valid, 0);
        chk("init_grant_id", grant_id, 0);
        chk("init_trunc", burst_truncated, 0);
        repeat (3) @(posedge clk);
        #2;
        rst      = 1'b1;
        in_reset = 1'b0;

        // Round robin between requesters 0 and 3
        log_q.delete();
        push_pkt(0, 1, 8'h01); push_pkt(0, 1, 8'h02);
        push_pkt(3, 1, 8'h31); push_pkt(3, 1, 8'h32);
        wait_idle("rr", 200);
        e = '{8'hA0, 8'h01, 8'hA3, 8'h31, 8'hA0, 8'h02, 8'hA3, 8'h32};
        chk_log("rr", e);

        // Single packet with backpressure on the header and on a data byte
        log_q.delete();
        trunc_seen = 0;
        push_pkt(0, 3, 8'h10);
        bp_cnt = 5;
        for (int c = 0; c < 100 && log_q.size() < 1; c++) begin
            @(posedge clk); #2;
        end
        bp_cnt = 5;
        wait_idle("single", 200);
        e = '{8'hA0, 8'h10, 8'h11, 8'h12};
        chk_log("single", e);
        chk("single_trunc", trunc_seen, 0);

        // Burst limit: requester 1 truncated after 4 beats, requester 2 next
        log_q.delete();
        trunc_seen = 0;
        push_pkt(1, 6, 8'h30);
        push_pkt(2, 1, 8'h20);
        wait_idle("burst", 300);
        e = '{8'hA1, 8'h30, 8'h31, 8'h32, 8'h33, 8'hA2, 8'h20, 8'hA1, 8'h34, 8'h35};
        chk_log("burst", e);
        chk("burst_trunc", trunc_seen, 1);

        // Random traffic with random backpressure and one reset mid-burst
        valid_pct  = 60;
        ready_rand = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (q[i].size() < 12 && $urandom_range(15) == 0)
                    push_pkt(i, int'($urandom_range(1, 8)), u8_t'($urandom));
            end
            if (!did_reset && cyc > 200 && m_phase == 2 && m_beats == 2) begin
                apply_reset();
                did_reset = 1'b1;
            end
        end
        if (!did_reset) apply_reset();
        ready_rand = 1'b0;
        valid_pct  = 100;
        wait_idle("drain", 3000);

        // After reset, requester 0 wins ahead of requester 2
        apply_reset();
        log_q.delete();
        push_pkt(2, 1, 8'h77);
        push_pkt(0, 1, 8'h55);
        wait_idle("post_rst", 200);
        e = '{8'hA0, 8'h55, 8'hA2, 8'h77};
        chk_log("post_rst", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locking arbiter that shares the single UART transmitter among `NUM_REQ` AXI-Stream byte sources. It sits directly in front of the UART's `s_axis_*` slave port. It can prefix each granted packet with a one-byte source header, so the far end can demultiplex the shared serial stream. A per-grant burst limit keeps one source from monopolising the link.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `DATA_WIDTH`, 8: byte width; matches the UART `DATA_WIDTH`.
- `HEADER_EN`, 1: 1 emits a header byte at the start of each grant; 0 emits no header.
- `HDR_BASE`, 8'hA0: header byte value is `HDR_BASE + grant_id`, modulo 256.
- `MAX_BURST`, 16: maximum data beats per grant; 0 means unlimited.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_tdata`  in  NUM_REQ*DATA_WIDTH  requester bytes; requester i uses slice [i*8 +: 8].
- `req_tvalid`  in  NUM_REQ  per-requester valid.
- `req_tlast`  in  NUM_REQ  per-requester end of packet.
- `req_tready`  out  NUM_REQ  per-requester ready.
- `m_axis_tdata`  out  DATA_WIDTH  byte to the UART `s_axis_tdata`.
- `m_axis_tvalid`  out  1  valid to the UART `s_axis_tvalid`.
- `m_axis_tready`  in  1  from the UART `s_axis_tready`.
- `grant_valid`  out  1  high while a requester holds the grant, in states HDR and DATA.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.
- `burst_truncated`  out  1  one-cycle pulse when a grant ends on `MAX_BURST` rather than on `tlast`.

## Operation
- **States:** IDLE, HDR, DATA; 2-bit register.
- **IDLE**
  - `m_axis_tvalid`=0, all `req_tready`=0.
  - If any `req_tvalid` is high, select the first valid requester scanning from `last_id+1` upward with wrap-around.
  - Register the selection as `grant_id` and clear the beat counter.
  - Next state is HDR if `HEADER_EN`, else DATA.
- **HDR**
  - Drive `m_axis_tdata`=`HDR_BASE+grant_id`, `m_axis_tvalid`=1, all `req_tready`=0.
  - On `m_axis_tvalid && m_axis_tready`, go to DATA.
- **DATA**
  - Combinational pass-through of the granted requester: `m_axis_tdata`=its slice, `m_axis_tvalid`=`req_tvalid[g]`, `req_tready[g]`=`m_axis_tready`.
  - All other `req_tready` bits stay 0.
  - Each handshake increments the beat counter; counter width is clog2(MAX_BURST+1).
- **Grant release** happens on a DATA handshake that meets either condition:
  - `req_tlast[g]`=1; or
  - beat count reaches `MAX_BURST` (when `MAX_BURST`≠0). This also asserts `burst_truncated` for the following cycle.
  - On release, `last_id` <= `grant_id` and the next state is IDLE. `tlast` and the burst limit in the same beat: release, no truncation pulse.
- The grant is held across requester valid gaps in DATA; `req_tvalid[g]` low only stalls the burst.
- `grant_id` holds its value in IDLE; `grant_valid`=0 in IDLE.
- `m_axis_tdata` is 0 whenever `m_axis_tvalid`=0.

## Timing
- **Reset values:**
  - state=IDLE, `last_id`=NUM_REQ-1 (requester 0 wins first), counter=0.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `req_tready`=0, `grant_valid`=0, `grant_id`=0, `burst_truncated`=0.
- **Latency:** a request sampled in IDLE at edge N gives `m_axis_tvalid` high after edge N.
  - With the header, the first data byte is accepted no earlier than the cycle after the header handshake.
  - After release, IDLE costs one cycle before the next grant (one bubble per packet).
- **AXI rules:**
  - `m_axis_tvalid` and `m_axis_tdata` stay stable while `m_axis_tready` is low in HDR.
  - In DATA, stability is inherited from the requester.
  - There is no combinational path from `m_axis_tready` to `m_axis_tvalid`.
- **Reset mid-operation:** all outputs go to reset values immediately and asynchronously.
  - A packet in flight is abandoned; the UART finishes any byte it already accepted.
  - After reset deassertion, arbitration restarts with requester 0 highest priority.
- **Simultaneous events:** a new request arriving during a release cycle is only considered in the following IDLE cycle.

## Test plan
- **Single packet, requester 0, `HEADER_EN`=1:** bytes 0x10, 0x11, 0x12 (tlast) -> `m_axis` carries A0, 10, 11, 12; `grant_valid` falls after 0x12; `burst_truncated` never pulses.
- **Round-robin fairness, `NUM_REQ`=4:** requesters 0 and 3 each continuously offer 1-byte packets -> grants alternate 0, 3, 0, 3; headers A0, A3 alternate.
- **Backpressure:** hold `m_axis_tready` low for 5 cycles during the header and then during byte 2 -> tdata/tvalid stay stable, `req_tready[g]`=0 during the hold, no byte lost or duplicated.
- **Burst limit, `MAX_BURST`=4:** requester 1 sends 6 bytes with no tlast while requester 2 waits.
  - `burst_truncated` pulses after beat 4.
  - Requester 2 is granted next (header A2).
  - Requester 1 later resumes with its bytes 5 and 6.
- **Reset mid-burst:** assert `rst` low after 2 data beats -> all outputs reach reset values asynchronously; after release, requester 0 is granted first.
- **UART loopback:** connect to the UART with txd looped to rxd, `prescale`=868; requester 2 sends 0x55 (tlast) -> UART `m_axis_tdata` receives A2 then 55, with no frame or overrun error.
